// File: rtl/prime_pair_finder.sv
// prime_pair_finder
// Requester side of the CheckPrime start/num -> finish/IsPrime handshake.
// Walks odd candidates upward from a seed, asks an external checker about
// each one, and keeps the first two distinct primes it hears about as the
// RSA pair (p, q). Gives up after a bounded number of requests or when the
// checker stays silent for too long on a single request.

module prime_pair_finder #(
  parameter int WIDTH          = 8,
  parameter int MAX_TRIES      = 64,
  parameter int TIMEOUT        = 16384,
  parameter int ACCEPT_ASSUMED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  output logic             chk_start,
  output logic [WIDTH-1:0] chk_num,
  input  logic             chk_finish,
  input  logic             chk_is_prime,
  input  logic             chk_assume_prime,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] q
);

  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int TMR_W   = $clog2(TIMEOUT + 1);
  localparam bit ACCEPT  = (ACCEPT_ASSUMED != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_FAIL
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [WIDTH-1:0]   cand;
  logic               found;
  logic [TRY_W-1:0]   tries;
  logic [TMR_W-1:0]   timer;

  logic               accept_start;
  logic               verdict;
  logic               pair_complete;
  logic               tries_exhausted;
  logic               timer_expired;
  logic [WIDTH-1:0]   odd_seed;
  logic [WIDTH-1:0]   seed_cand;
  logic [WIDTH:0]     cand_plus_two;
  logic [WIDTH-1:0]   next_cand;

  // Start is only honoured when no scan is in flight.
  assign accept_start = start &&
                        ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL));

  // Assumed-prime verdicts only count when the build opts into them.
  assign verdict       = chk_is_prime | (ACCEPT & chk_assume_prime);
  assign pair_complete = verdict & found & (cand != p);

  assign tries_exhausted = (tries == TRY_W'(MAX_TRIES));
  assign timer_expired   = (timer == TMR_W'(TIMEOUT - 1));

  // First candidate is the seed forced odd, never below 3 (2 is never tried).
  assign odd_seed  = seed | WIDTH'(1);
  assign seed_cand = (odd_seed < WIDTH'(3)) ? WIDTH'(3) : odd_seed;

  // Step by two; running off the top of the range restarts the scan at 3.
  assign cand_plus_two = {1'b0, cand} + (WIDTH + 1)'(2);
  assign next_cand     = cand_plus_two[WIDTH] ? WIDTH'(3) : cand_plus_two[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; a checker answer in the last allowed cycle beats the timeout.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (accept_start) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (chk_finish) begin
          if (pair_complete) begin
            state_next = ST_DONE;
          end else if (tries_exhausted) begin
            state_next = ST_FAIL;
          end else begin
            state_next = ST_ISSUE;
          end
        end else if (timer_expired) begin
          state_next = ST_FAIL;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Scan datapath: candidate, collected primes, request and wait counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand  <= '0;
      p     <= '0;
      q     <= '0;
      found <= 1'b0;
      tries <= '0;
      timer <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (accept_start) begin
            cand  <= seed_cand;
            p     <= '0;
            q     <= '0;
            found <= 1'b0;
            tries <= '0;
            timer <= '0;
          end
        end
        ST_ISSUE: begin
          tries <= tries + TRY_W'(1);
          timer <= '0;
        end
        ST_WAIT: begin
          if (chk_finish) begin
            if (verdict && !found) begin
              p     <= cand;
              found <= 1'b1;
            end else if (pair_complete) begin
              q <= cand;
            end
            cand <= next_cand;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status and request strobes follow directly from the current state.
  always_comb begin
    chk_start = (state == ST_ISSUE);
    busy      = (state == ST_ISSUE) || (state == ST_WAIT);
    done      = (state == ST_DONE);
    fail      = (state == ST_FAIL);
  end

  assign chk_num = cand;

endmodule

// File: tb/tb_prime_pair_finder.sv
// tb_prime_pair_finder
// Scoreboard bench for prime_pair_finder: a reference model predicts the
// candidate sequence and final outcome of each scan from the seed and the
// checker verdict tables, a responder plays the external checker, and a
// monitor compares every request and every completion against the queues.

module tb_prime_pair_finder;

  localparam int WIDTH     = 8;
  localparam int MAX_TRIES = 8;
  localparam int TIMEOUT   = 40;
  localparam int ACCEPT    = 1;

  localparam int K_TRUTH     = 0;
  localparam int K_COMPOSITE = 1;
  localparam int K_ASSUME    = 2;
  localparam int K_RANDOM    = 3;

  typedef struct {
    bit is_done;
    int p;
    int q;
    int lat;
  } result_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] seed;
  logic             chk_start;
  logic [WIDTH-1:0] chk_num;
  logic             chk_finish;
  logic             chk_is_prime;
  logic             chk_assume_prime;
  logic             busy;
  logic             done;
  logic             fail;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;

  int      exp_num[$];
  result_t exp_res[$];
  bit      v_is[256];
  bit      v_as[256];
  bit      never_finish;
  int      fixed_delay;
  int      checks;
  int      failures;
  int      cycle;
  int      last_start;
  bit      prev_done;
  bit      prev_fail;

  prime_pair_finder #(
    .WIDTH(WIDTH),
    .MAX_TRIES(MAX_TRIES),
    .TIMEOUT(TIMEOUT),
    .ACCEPT_ASSUMED(ACCEPT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .seed(seed),
    .chk_start(chk_start),
    .chk_num(chk_num),
    .chk_finish(chk_finish),
    .chk_is_prime(chk_is_prime),
    .chk_assume_prime(chk_assume_prime),
    .busy(busy),
    .done(done),
    .fail(fail),
    .p(p),
    .q(q)
  );

  // Free-running clock, posedge at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit isPrime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Fill the verdict tables the checker answers from.
  task automatic setVerdicts(input int kind);
    for (int n = 0; n < 256; n++) begin
      bit t;
      int split;
      t = isPrime(n);
      v_is[n] = 1'b0;
      v_as[n] = 1'b0;
      case (kind)
        K_TRUTH:  v_is[n] = t;
        K_ASSUME: v_as[n] = t;
        K_RANDOM: begin
          if ($urandom_range(0, 15) == 0) t = !t;
          if (t) begin
            split = $urandom_range(0, 2);
            v_is[n] = (split != 1);
            v_as[n] = (split != 0);
          end
        end
        default: begin
        end
      endcase
    end
  endtask

  // Reference model: walk the odd numbers the way the scan is described.
  task automatic predictRun(input int seed_val, input bit timeout_run);
    int      cand;
    int      fp;
    int      fq;
    bit      found;
    bit      fin;
    bit      prime;
    result_t r;
    cand = seed_val | 1;
    if (cand < 3) cand = 3;
    fp = 0;
    fq = 0;
    found = 1'b0;
    fin = 1'b0;
    if (timeout_run) begin
      exp_num.push_back(cand);
      r = '{is_done: 1'b0, p: 0, q: 0, lat: TIMEOUT + 1};
      exp_res.push_back(r);
      return;
    end
    for (int t = 0; t < MAX_TRIES && !fin; t++) begin
      exp_num.push_back(cand);
      prime = v_is[cand] || (ACCEPT != 0 && v_as[cand]);
      if (prime) begin
        if (!found) begin
          fp = cand;
          found = 1'b1;
        end else if (cand != fp) begin
          fq = cand;
          fin = 1'b1;
        end
      end
      cand = (cand + 2 > 255) ? 3 : cand + 2;
    end
    r = '{is_done: fin, p: fp, q: fq, lat: 0};
    exp_res.push_back(r);
  endtask

  // Asynchronous reset off the clock edge; every output must drop at once.
  task automatic resetCheck(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput({tag, " chk_start"}, chk_start, 0);
    checkOutput({tag, " chk_num"}, chk_num, 0);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " fail"}, fail, 0);
    checkOutput({tag, " p"}, p, 0);
    checkOutput({tag, " q"}, q, 0);
    exp_num.delete();
    exp_res.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Launch one scan, optionally poke start mid-run, and wait for its end.
  task automatic applyStimulus(input int seed_val, input int kind, input bit never,
                               input int delay, input bit poke);
    int waited;
    setVerdicts(kind);
    never_finish = never;
    fixed_delay  = delay;
    predictRun(seed_val, never);
    @(negedge clk);
    start = 1'b1;
    seed  = WIDTH'(seed_val);
    @(negedge clk);
    start = 1'b0;
    seed  = WIDTH'($urandom);
    checkOutput("busy after start", busy, 1);
    checkOutput("done cleared by start", done, 0);
    checkOutput("fail cleared by start", fail, 0);
    checkOutput("p cleared by start", p, 0);
    checkOutput("q cleared by start", q, 0);
    if (poke) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      seed  = WIDTH'($urandom_range(0, 255));
      @(negedge clk);
      start = 1'b0;
    end
    waited = 0;
    while (!(done || fail) && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!(done || fail)) begin
      checkOutput("run completion", 0, 1);
      resetCheck("recovery");
    end else begin
      repeat (3) @(negedge clk);
      checkOutput("scoreboard drained", exp_num.size() + exp_res.size(), 0);
    end
  endtask

  // Checker model: answer each request after 2+ cycles from the verdict tables.
  initial begin
    int n;
    int d;
    chk_finish       = 1'b0;
    chk_is_prime     = 1'b0;
    chk_assume_prime = 1'b0;
    forever begin
      @(negedge clk);
      while (rst_n && chk_start && !never_finish) begin
        n = int'(chk_num);
        d = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
        @(negedge clk);
        repeat (d) @(negedge clk);
        chk_finish       = 1'b1;
        chk_is_prime     = v_is[n];
        chk_assume_prime = v_as[n];
        @(negedge clk);
        chk_finish       = 1'b0;
        chk_is_prime     = 1'($urandom);
        chk_assume_prime = 1'($urandom);
      end
    end
  end

  // Monitor: compare each request and each completion with the scoreboard.
  initial begin
    int      e;
    result_t r;
    cycle      = 0;
    last_start = 0;
    prev_done  = 1'b0;
    prev_fail  = 1'b0;
    forever begin
      @(negedge clk);
      cycle++;
      if (rst_n) begin
        if (chk_start) begin
          if (exp_num.size() == 0) begin
            checkOutput("unexpected chk_start", int'(chk_num), -1);
          end else begin
            e = exp_num.pop_front();
            checkOutput("chk_num", int'(chk_num), e);
          end
          last_start = cycle;
        end
        if ((done && !prev_done) || (fail && !prev_fail)) begin
          if (exp_res.size() == 0) begin
            checkOutput("unexpected completion", int'(done), -1);
          end else begin
            r = exp_res.pop_front();
            checkOutput("done", int'(done), int'(r.is_done));
            checkOutput("fail", int'(fail), int'(!r.is_done));
            checkOutput("p", int'(p), r.p);
            checkOutput("q", int'(q), r.q);
            checkOutput("busy at end", int'(busy), 0);
            if (r.lat > 0) begin
              checkOutput("timeout latency", cycle - last_start, r.lat);
            end
          end
        end
      end
      prev_done = done;
      prev_fail = fail;
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios first, then randomized scans.
  initial begin
    int d;
    bit pk;
    rst_n        = 1'b1;
    start        = 1'b0;
    seed         = '0;
    never_finish = 1'b0;
    fixed_delay  = -1;
    checks       = 0;
    failures     = 0;

    resetCheck("reset");

    applyStimulus(7,   K_TRUTH,     1'b0, -1, 1'b0);
    applyStimulus(8,   K_TRUTH,     1'b0, -1, 1'b0);
    applyStimulus(0,   K_TRUTH,     1'b0, -1, 1'b0);
    applyStimulus(251, K_TRUTH,     1'b0, -1, 1'b0);
    applyStimulus(100, K_COMPOSITE, 1'b0, -1, 1'b0);
    applyStimulus(7,   K_TRUTH,     1'b1, -1, 1'b0);
    applyStimulus(7,   K_TRUTH,     1'b0, TIMEOUT - 1, 1'b0);
    applyStimulus(20,  K_ASSUME,    1'b0, -1, 1'b0);
    applyStimulus(7,   K_TRUTH,     1'b0, 2, 1'b1);

    setVerdicts(K_TRUTH);
    never_finish = 1'b0;
    fixed_delay  = -1;
    predictRun(7, 1'b0);
    @(negedge clk);
    start = 1'b1;
    seed  = WIDTH'(7);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    resetCheck("mid-run reset");

    for (int i = 0; i < 40; i++) begin
      d  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(2, 6));
      pk = (d >= 2) && ($urandom_range(0, 1) == 1);
      applyStimulus(int'($urandom_range(0, 255)), K_RANDOM, 1'b0, d, pk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
